// File: rtl/iir_pkg.sv
// Shared defaults, FSM state type and checksum step for the IIR stimulus/capture block.
// Sizes follow the filter datapath: 24-bit signed samples, 2048-entry buffers.
package iir_pkg;

    localparam int DEF_DW     = 24;
    localparam int DEF_DEPTH  = 2048;
    localparam int DEF_AW     = 11;
    localparam int DEF_GAP_W  = 8;
    localparam int DEF_TO_CYC = 200000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Rotate-left-by-one then fold in the sign-extended sample.
    function automatic logic [31:0] cs_next(input logic [31:0] cs, input logic [31:0] x);
        return {cs[30:0], cs[31]} ^ x;
    endfunction

endpackage

// File: rtl/iir_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
// Read data appears one cycle after the address; re=0 holds the last read word.
module iir_sdp_ram
    import iir_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; array contents are undefined after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/iir_stim_capture.sv
// On-chip stimulus player and response capture for the IIR filter: first sample 2 cycles after start,
// one sample per (gap+1) cycles; no backpressure from the filter, beats beyond DEPTH are dropped.
module iir_stim_capture
    import iir_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = DEF_AW,
    parameter int GAP_W  = DEF_GAP_W,
    parameter int TO_CYC = DEF_TO_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW:0]      n_samples,
    input  logic [GAP_W-1:0] gap,
    input  logic             stim_we,
    input  logic [AW-1:0]    stim_waddr,
    input  logic [DW-1:0]    stim_wdata,
    output logic [DW-1:0]    dut_data_in,
    output logic             dut_valid_in,
    input  logic [DW-1:0]    dut_data_out,
    input  logic             dut_valid_out,
    input  logic [AW-1:0]    cap_raddr,
    output logic [DW-1:0]    cap_rdata,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             overflow,
    output logic [AW:0]      out_count,
    output logic [31:0]      latency,
    output logic [31:0]      cycle_cnt,
    output logic [31:0]      checksum
);

    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [31:0] TO_LAST = 32'(TO_CYC - 1);

    state_t           state, state_nxt;
    logic [AW:0]      n_reg, ptr;
    logic [GAP_W-1:0] gap_reg, gap_cnt;
    logic [31:0]      dcnt;
    logic             lat_run, lat_frz;
    logic             start_ok, issue, last_issue;
    logic             cap_beat, cap_full, cap_wr, drain_hit, to_hit;

    assign busy       = (state == PLAY) || (state == DRAIN);
    assign done       = (state == DONE);
    assign start_ok   = start && ((state == IDLE) || (state == DONE));
    assign issue      = (state == PLAY) && (gap_cnt == '0);
    assign last_issue = issue && (ptr == n_reg - 1'b1);
    assign cap_beat   = busy && dut_valid_out;
    assign cap_full   = (out_count == FULL);
    assign cap_wr     = cap_beat && !cap_full;
    // Completion counts the beat being captured this cycle so DONE follows the last beat directly.
    assign drain_hit  = (out_count == n_reg) || (cap_wr && (out_count + 1'b1 == n_reg));
    assign to_hit     = (dcnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (n_samples == '0) ? DONE : PLAY;
            PLAY:       if (last_issue) state_nxt = DRAIN;
            DRAIN:      if (drain_hit || to_hit) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg        <= '0;
            gap_reg      <= '0;
            ptr          <= '0;
            gap_cnt      <= '0;
            dcnt         <= '0;
            out_count    <= '0;
            latency      <= '0;
            cycle_cnt    <= '0;
            checksum     <= '0;
            timeout      <= 1'b0;
            overflow     <= 1'b0;
            lat_run      <= 1'b0;
            lat_frz      <= 1'b0;
            dut_valid_in <= 1'b0;
        end else if (start_ok) begin
            n_reg        <= n_samples;
            gap_reg      <= gap;
            ptr          <= '0;
            gap_cnt      <= '0;
            dcnt         <= '0;
            out_count    <= '0;
            latency      <= '0;
            cycle_cnt    <= '0;
            checksum     <= '0;
            timeout      <= 1'b0;
            overflow     <= 1'b0;
            lat_run      <= 1'b0;
            lat_frz      <= 1'b0;
            dut_valid_in <= 1'b0;
        end else begin
            // The RAM read issued this cycle lands on dut_data_in together with this valid.
            dut_valid_in <= issue;
            if (issue) begin
                ptr     <= ptr + 1'b1;
                gap_cnt <= gap_reg;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            if (busy) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (state == DRAIN) begin
                dcnt <= dcnt + 32'd1;
            end
            if (cap_wr) begin
                out_count <= out_count + 1'b1;
                checksum  <= cs_next(checksum, {{(32-DW){dut_data_out[DW-1]}}, dut_data_out});
            end
            if (cap_beat && cap_full) begin
                overflow <= 1'b1;
            end
            if (busy && !lat_frz) begin
                if (dut_valid_out) begin
                    lat_frz <= 1'b1;
                end else if (lat_run || dut_valid_in) begin
                    latency <= latency + 32'd1;
                    lat_run <= 1'b1;
                end
            end
            if ((state == DRAIN) && to_hit && !drain_hit) begin
                timeout <= 1'b1;
            end
        end
    end

    iir_sdp_ram #(.DW(DW), .AW(AW)) u_stim_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (stim_we && !busy),
        .waddr (stim_waddr),
        .wdata (stim_wdata),
        .re    (issue),
        .raddr (ptr[AW-1:0]),
        .rdata (dut_data_in)
    );

    iir_sdp_ram #(.DW(DW), .AW(AW)) u_cap_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (cap_wr),
        .waddr (out_count[AW-1:0]),
        .wdata (dut_data_out),
        .re    (1'b1),
        .raddr (cap_raddr),
        .rdata (cap_rdata)
    );

endmodule
